// File: rtl/issue_scoreboard_pkg.sv
// Shared types and operand-usage decode for the issue scoreboard.
// Opcode values follow the RV32I base encoding.
package issue_scoreboard_pkg;

  typedef enum logic [6:0] {
    OP_LUI      = 7'b0110111,
    OP_AUIPC    = 7'b0010111,
    OP_JAL      = 7'b1101111,
    OP_JALR     = 7'b1100111,
    OP_BRANCH   = 7'b1100011,
    OP_LOAD     = 7'b0000011,
    OP_STORE    = 7'b0100011,
    OP_ALU_IMM  = 7'b0010011,
    OP_ALU      = 7'b0110011,
    OP_MISC_MEM = 7'b0001111,
    OP_SYSTEM   = 7'b1110011
  } opcode_t;

  typedef struct packed {
    logic rs1_used;
    logic rs2_used;
    logic rd_written;
  } reg_use_t;

  // Takes raw opcode bits so unknown encodings fall to the default (rs1 read, no rd write)
  // without an enum cast. SYSTEM with funct3!=0 is a CSR access; funct3==0 is ECALL/EBREAK.
  function automatic reg_use_t reg_use(input logic [6:0] op, input logic [2:0] funct3);
    reg_use_t u;
    u.rs1_used   = 1'b1;
    u.rs2_used   = 1'b0;
    u.rd_written = 1'b0;
    case (op)
      OP_LUI, OP_AUIPC, OP_JAL: begin
        u.rs1_used   = 1'b0;
        u.rd_written = 1'b1;
      end
      OP_JALR, OP_LOAD, OP_ALU_IMM: u.rd_written = 1'b1;
      OP_ALU: begin
        u.rs2_used   = 1'b1;
        u.rd_written = 1'b1;
      end
      OP_BRANCH, OP_STORE: u.rs2_used = 1'b1;
      OP_MISC_MEM:         u.rs1_used = 1'b0;
      OP_SYSTEM: begin
        u.rs1_used   = (funct3 != 3'd0);
        u.rd_written = (funct3 != 3'd0);
      end
      default: ;
    endcase
    return u;
  endfunction

endpackage

// File: rtl/issue_scoreboard_hazard_check.sv
// Combinational RAW/WAW hazard and capacity check for the instruction at decode.
module issue_hazard_check
  import issue_scoreboard_pkg::*;
#(
  parameter int MAX_INFLIGHT = 4,
  parameter int CNT_W        = 4
) (
  input  logic [31:0]      t_instr,
  input  logic [31:0]      pend,
  input  logic [CNT_W-1:0] inflight_eff,
  output logic             hazard,
  output logic             full,
  output logic             tracked
);

  logic [4:0] rs1;
  logic [4:0] rs2;
  logic [4:0] rd;
  reg_use_t   use_w;
  logic       unused_funct7;

  assign rs1           = t_instr[19:15];
  assign rs2           = t_instr[24:20];
  assign rd            = t_instr[11:7];
  assign unused_funct7 = ^t_instr[31:25];

  assign use_w   = reg_use(t_instr[6:0], t_instr[14:12]);
  assign tracked = use_w.rd_written & (rd != 5'd0);

  assign hazard = (use_w.rs1_used & pend[rs1])
                | (use_w.rs2_used & pend[rs2])
                | (tracked        & pend[rd]);

  assign full = tracked & (inflight_eff == CNT_W'(MAX_INFLIGHT));

endmodule

// File: rtl/issue_scoreboard.sv
// Issue scoreboard: pending-write tracking and hazard-gated decode->execute handshake.
// Define SCOREBOARD_WB_BYPASS_EN to let a consumer issue in its producer's writeback cycle.
module issue_scoreboard
  import issue_scoreboard_pkg::*;
#(
  parameter int MAX_INFLIGHT = 4,
  parameter int CNT_W        = 4
) (
  input  logic             clk,
  input  logic             rstf,
  input  logic [31:0]      t_instr,
  input  logic             t_valid,
  output logic             t_ready,
  output logic             i_valid,
  input  logic             i_ready,
  input  logic             wb_valid,
  input  logic [4:0]       wb_rd,
  input  logic             flush,
  output logic [31:0]      busy_mask,
  output logic [CNT_W-1:0] inflight,
  output logic             sb_err
);

  logic [31:0]      pend_q, pend_d, pend_eff;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_eff;
  logic             err_q;
  logic             wb_hit;
  logic             hazard, full, tracked;
  logic             gate, issue, set_rd;
  logic [4:0]       rd;

  // x0 is never set, so a hit also excludes writebacks to x0.
  assign wb_hit = wb_valid & pend_q[wb_rd];
  assign rd     = t_instr[11:7];

`ifdef SCOREBOARD_WB_BYPASS_EN
  logic [31:0] wb_onehot;
  assign wb_onehot = wb_valid ? (32'd1 << wb_rd) : 32'd0;
  assign pend_eff  = pend_q & ~wb_onehot;
  assign cnt_eff   = cnt_q - CNT_W'(wb_hit);
`else
  assign pend_eff  = pend_q;
  assign cnt_eff   = cnt_q;
`endif

  issue_hazard_check #(
    .MAX_INFLIGHT (MAX_INFLIGHT),
    .CNT_W        (CNT_W)
  ) u_hazard (
    .t_instr      (t_instr),
    .pend         (pend_eff),
    .inflight_eff (cnt_eff),
    .hazard       (hazard),
    .full         (full),
    .tracked      (tracked)
  );

  // Reset is folded in so the handshake stays closed while rstf is held low.
  assign gate    = ~hazard & ~full & ~flush & rstf;
  assign i_valid = t_valid & gate;
  assign t_ready = i_ready & gate;
  assign issue   = i_valid & i_ready;
  assign set_rd  = issue & tracked;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    pend_d = pend_q;
    cnt_d  = cnt_q;
    if (flush) begin
      pend_d = '0;
      cnt_d  = '0;
    end else begin
      // Clear before set: same-register writeback and reissue leaves the bit set.
      if (wb_hit) pend_d[wb_rd] = 1'b0;
      if (set_rd) pend_d[rd]    = 1'b1;
      case ({set_rd, wb_hit})
        2'b10:   cnt_d = cnt_q + CNT_W'(1);
        2'b01:   cnt_d = cnt_q - CNT_W'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstf) begin
    if (!rstf) begin
      pend_q <= '0;
      cnt_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking so every flop here samples pre-edge values of the others.
      pend_q <= pend_d;
      cnt_q  <= cnt_d;
      if (wb_valid & ~wb_hit & ~flush) err_q <= 1'b1;
    end
  end

  assign busy_mask = pend_q;
  assign inflight  = cnt_q;
  assign sb_err    = err_q;

endmodule

// File: tb/tb_issue_scoreboard.sv
// Self-checking bench for issue_scoreboard: directed scenarios plus randomized traffic
// against a pending-set reference model (inflight modelled as the number of pending regs).
module tb_issue_scoreboard;

  localparam int MAX_INFLIGHT = 4;
  localparam int CNT_W        = 4;
`ifdef SCOREBOARD_WB_BYPASS_EN
  localparam int BYPASS = 1;
`else
  localparam int BYPASS = 0;
`endif

  localparam logic [6:0] B_LUI = 7'h37, B_AUIPC = 7'h17, B_JAL = 7'h6F, B_JALR = 7'h67;
  localparam logic [6:0] B_BRANCH = 7'h63, B_LOAD = 7'h03, B_STORE = 7'h23;
  localparam logic [6:0] B_ALU_IMM = 7'h13, B_ALU = 7'h33, B_MISC_MEM = 7'h0F, B_SYS = 7'h73;

  logic             clk = 1'b0;
  logic             rstf;
  logic [31:0]      t_instr;
  logic             t_valid, t_ready, i_valid, i_ready;
  logic             wb_valid, flush;
  logic [4:0]       wb_rd;
  logic [31:0]      busy_mask;
  logic [CNT_W-1:0] inflight;
  logic             sb_err;

  int checks = 0;
  int errors = 0;

  bit [31:0] pend_m;
  bit        err_m;
  bit        exp_iv, exp_tr, act_iv, act_tr;

  issue_scoreboard #(.MAX_INFLIGHT(MAX_INFLIGHT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rstf(rstf), .t_instr(t_instr), .t_valid(t_valid), .t_ready(t_ready),
    .i_valid(i_valid), .i_ready(i_ready), .wb_valid(wb_valid), .wb_rd(wb_rd),
    .flush(flush), .busy_mask(busy_mask), .inflight(inflight), .sb_err(sb_err)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] enc(input logic [6:0] op, input int rd, input int f3,
                                      input int rs1, input int rs2);
    return {7'd0, rs2[4:0], rs1[4:0], f3[2:0], rd[4:0], op};
  endfunction

  function automatic void decode(input logic [31:0] ins, output bit r1u, output bit r2u,
                                 output bit rdw);
    logic [6:0] op;
    bit csr;
    op  = ins[6:0];
    csr = (ins[14:12] != 3'd0);
    r2u = (op == B_BRANCH) || (op == B_STORE) || (op == B_ALU);
    rdw = (op inside {B_LUI, B_AUIPC, B_JAL, B_JALR, B_LOAD, B_ALU, B_ALU_IMM})
          || (op == B_SYS && csr);
    r1u = !((op inside {B_LUI, B_AUIPC, B_JAL, B_MISC_MEM}) || (op == B_SYS && !csr));
  endfunction

  function automatic bit model_tracked();
    bit r1u, r2u, rdw;
    decode(t_instr, r1u, r2u, rdw);
    return rdw && (t_instr[11:7] != 5'd0);
  endfunction

  // Whether the presented instruction may pass this cycle, from the model's pending set.
  function automatic bit model_go();
    bit r1u, r2u, rdw, trk;
    bit [31:0] p;
    decode(t_instr, r1u, r2u, rdw);
    trk = model_tracked();
    p   = pend_m;
    if (BYPASS != 0 && wb_valid) p[wb_rd] = 1'b0;
    if (!rstf || flush) return 1'b0;
    if (r1u && p[t_instr[19:15]]) return 1'b0;
    if (r2u && p[t_instr[24:20]]) return 1'b0;
    if (trk && p[t_instr[11:7]]) return 1'b0;
    if (trk && $countones(p) >= MAX_INFLIGHT) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_update();
    if (!rstf) begin
      pend_m = '0;
      err_m  = 1'b0;
    end else if (flush) begin
      pend_m = '0;
    end else begin
      if (wb_valid) begin
        if (pend_m[wb_rd]) pend_m[wb_rd] = 1'b0;
        else err_m = 1'b1;
      end
      if (exp_iv && i_ready && model_tracked()) pend_m[t_instr[11:7]] = 1'b1;
    end
  endtask

  // Inputs are already driven (just after a falling edge); sample, clock once, update model.
  task automatic tick();
    bit go;
    #1;
    go     = model_go();
    exp_iv = t_valid && go;
    exp_tr = i_ready && go;
    act_iv = i_valid;
    act_tr = t_ready;
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rstf = 1'b0; t_instr = '0; t_valid = 1'b0; i_ready = 1'b0;
    wb_valid = 1'b0; wb_rd = '0; flush = 1'b0;
    repeat (2) @(negedge clk);
    rstf = 1'b1;
    pend_m = '0;
    err_m  = 1'b0;
  endtask

  task automatic test_reset();
    rstf = 1'b0; t_instr = enc(B_ALU, 3, 0, 1, 2); t_valid = 1'b1; i_ready = 1'b1;
    wb_valid = 1'b0; wb_rd = '0; flush = 1'b0;
    #3;
    checks++; if (i_valid !== 1'b0) begin errors++; $display("FAIL reset_i_valid: got %0b expected 0", i_valid); end
    checks++; if (t_ready !== 1'b0) begin errors++; $display("FAIL reset_t_ready: got %0b expected 0", t_ready); end
    checks++; if (busy_mask !== 32'h0) begin errors++; $display("FAIL reset_busy: got %h expected 0", busy_mask); end
    checks++; if (inflight !== 4'd0) begin errors++; $display("FAIL reset_inflight: got %0d expected 0", inflight); end
    checks++; if (sb_err !== 1'b0) begin errors++; $display("FAIL reset_sb_err: got %0b expected 0", sb_err); end
    do_reset();
  endtask

  task automatic test_raw();
    int wait_n;
    do_reset();
    t_valid = 1'b1; i_ready = 1'b1; t_instr = enc(B_ALU, 3, 0, 1, 2);
    tick();
    checks++; if (act_iv !== 1'b1) begin errors++; $display("FAIL raw_add_issue: got %0b expected 1", act_iv); end
    checks++; if (busy_mask[3] !== 1'b1) begin errors++; $display("FAIL raw_busy3: got %0b expected 1", busy_mask[3]); end
    t_instr = enc(B_ALU_IMM, 4, 0, 3, 1);
    repeat (2) begin
      tick();
      checks++; if (act_tr !== 1'b0) begin errors++; $display("FAIL raw_stall: got t_ready=%0b expected 0", act_tr); end
    end
    wb_valid = 1'b1; wb_rd = 5'd3;
    wait_n = -1;
    for (int c = 0; c < 4; c++) begin
      tick();
      wb_valid = 1'b0;
      if (act_tr) begin
        wait_n = c;
        break;
      end
    end
    t_valid = 1'b0;
    checks++; if (wait_n != BYPASS ? 1'b0 : 1'b0) begin end
    checks--;
    checks++; if (wait_n != (BYPASS != 0 ? 0 : 1)) begin errors++; $display("FAIL raw_issue_cycle: got %0d expected %0d", wait_n, (BYPASS != 0 ? 0 : 1)); end
    checks++; if (busy_mask !== 32'h10) begin errors++; $display("FAIL raw_busy_after: got %h expected 00000010", busy_mask); end
    checks++; if (inflight !== 4'd1) begin errors++; $display("FAIL raw_inflight: got %0d expected 1", inflight); end
  endtask

  task automatic test_capacity();
    do_reset();
    t_valid = 1'b1; i_ready = 1'b1;
    for (int r = 5; r <= 8; r++) begin
      t_instr = enc(B_LOAD, r, 2, 0, 0);
      tick();
      checks++; if (act_iv !== 1'b1) begin errors++; $display("FAIL cap_load_x%0d: got %0b expected 1", r, act_iv); end
    end
    checks++; if (inflight !== 4'd4) begin errors++; $display("FAIL cap_inflight: got %0d expected 4", inflight); end
    t_instr = enc(B_LOAD, 9, 2, 0, 0);
    tick();
    checks++; if (act_tr !== 1'b0) begin errors++; $display("FAIL cap_fifth_stall: got %0b expected 0", act_tr); end
    t_instr = enc(B_STORE, 0, 2, 2, 1);
    tick();
    t_valid = 1'b0;
    checks++; if (act_iv !== 1'b1) begin errors++; $display("FAIL cap_store_issue: got %0b expected 1", act_iv); end
    checks++; if (busy_mask !== 32'h1E0) begin errors++; $display("FAIL cap_busy: got %h expected 000001e0", busy_mask); end
    checks++; if (inflight !== 4'd4) begin errors++; $display("FAIL cap_inflight_after: got %0d expected 4", inflight); end
  endtask

  task automatic test_waw();
    int wait_n;
    bit b7;
    do_reset();
    t_valid = 1'b1; i_ready = 1'b1; t_instr = enc(B_LUI, 7, 0, 0, 0);
    tick();
    checks++; if (act_iv !== 1'b1) begin errors++; $display("FAIL waw_first: got %0b expected 1", act_iv); end
    tick();
    checks++; if (act_tr !== 1'b0) begin errors++; $display("FAIL waw_stall: got %0b expected 0", act_tr); end
    wb_valid = 1'b1; wb_rd = 5'd7;
    wait_n = -1;
    b7 = 1'b0;
    for (int c = 0; c < 4; c++) begin
      tick();
      if (c == 0) b7 = busy_mask[7];
      wb_valid = 1'b0;
      if (act_tr) begin
        wait_n = c;
        break;
      end
    end
    t_valid = 1'b0;
    checks++; if (wait_n != (BYPASS != 0 ? 0 : 1)) begin errors++; $display("FAIL waw_issue_cycle: got %0d expected %0d", wait_n, (BYPASS != 0 ? 0 : 1)); end
    checks++; if (b7 != (BYPASS != 0)) begin errors++; $display("FAIL waw_set_wins: got %0b expected %0b", b7, (BYPASS != 0)); end
    checks++; if (busy_mask !== 32'h80) begin errors++; $display("FAIL waw_busy: got %h expected 00000080", busy_mask); end
    checks++; if (inflight !== 4'd1) begin errors++; $display("FAIL waw_inflight: got %0d expected 1", inflight); end
  endtask

  // Runs on the state left by test_waw: only x7 pending.
  task automatic test_bad_wb();
    t_valid = 1'b0;
    checks++; if (sb_err !== 1'b0) begin errors++; $display("FAIL badwb_pre: got %0b expected 0", sb_err); end
    wb_valid = 1'b1; wb_rd = 5'd9;
    tick();
    wb_valid = 1'b0;
    checks++; if (sb_err !== 1'b1) begin errors++; $display("FAIL badwb_sb_err: got %0b expected 1", sb_err); end
    checks++; if (busy_mask !== 32'h80) begin errors++; $display("FAIL badwb_busy: got %h expected 00000080", busy_mask); end
    checks++; if (inflight !== 4'd1) begin errors++; $display("FAIL badwb_inflight: got %0d expected 1", inflight); end
    wb_valid = 1'b1; wb_rd = 5'd0;
    tick();
    wb_valid = 1'b0;
    tick();
    checks++; if (sb_err !== 1'b1) begin errors++; $display("FAIL badwb_sticky: got %0b expected 1", sb_err); end
    checks++; if (busy_mask !== 32'h80) begin errors++; $display("FAIL badwb_x0_busy: got %h expected 00000080", busy_mask); end
  endtask

  task automatic test_flush();
    do_reset();
    t_valid = 1'b1; i_ready = 1'b1;
    for (int r = 10; r <= 12; r++) begin
      t_instr = enc(B_LUI, r, 0, 0, 0);
      tick();
    end
    checks++; if (inflight !== 4'd3) begin errors++; $display("FAIL flush_pre_inflight: got %0d expected 3", inflight); end
    t_instr = enc(B_ALU, 13, 0, 10, 11);
    flush = 1'b1; wb_valid = 1'b1; wb_rd = 5'd10;
    tick();
    flush = 1'b0; wb_valid = 1'b0;
    checks++; if (act_iv !== 1'b0) begin errors++; $display("FAIL flush_no_issue: got %0b expected 0", act_iv); end
    checks++; if (busy_mask !== 32'h0) begin errors++; $display("FAIL flush_busy: got %h expected 0", busy_mask); end
    checks++; if (inflight !== 4'd0) begin errors++; $display("FAIL flush_inflight: got %0d expected 0", inflight); end
    checks++; if (sb_err !== 1'b0) begin errors++; $display("FAIL flush_wb_discard: got %0b expected 0", sb_err); end
    tick();
    t_valid = 1'b0;
    checks++; if (act_iv !== 1'b1) begin errors++; $display("FAIL flush_held_issue: got %0b expected 1", act_iv); end
    checks++; if (busy_mask !== 32'h2000) begin errors++; $display("FAIL flush_busy_after: got %h expected 00002000", busy_mask); end
  endtask

  task automatic test_async_reset();
    do_reset();
    t_valid = 1'b1; i_ready = 1'b1; t_instr = enc(B_LUI, 5, 0, 0, 0);
    tick();
    t_instr = enc(B_ALU, 6, 0, 5, 5);
    wb_valid = 1'b1; wb_rd = 5'd20;
    tick();
    wb_valid = 1'b0;
    checks++; if (sb_err !== 1'b1 || busy_mask[5] !== 1'b1) begin errors++; $display("FAIL arst_pre: got sb_err=%0b busy5=%0b expected 1 1", sb_err, busy_mask[5]); end
    #2;
    rstf = 1'b0;
    #1;
    checks++; if (busy_mask !== 32'h0 || inflight !== 4'd0 || sb_err !== 1'b0) begin errors++; $display("FAIL arst_state: got busy=%h inflight=%0d sb_err=%0b expected 0 0 0", busy_mask, inflight, sb_err); end
    checks++; if (i_valid !== 1'b0 || t_ready !== 1'b0) begin errors++; $display("FAIL arst_handshake: got i_valid=%0b t_ready=%0b expected 0 0", i_valid, t_ready); end
    @(posedge clk);
    #1;
    checks++; if (i_valid !== 1'b0 || t_ready !== 1'b0) begin errors++; $display("FAIL arst_held: got i_valid=%0b t_ready=%0b expected 0 0", i_valid, t_ready); end
    @(negedge clk);
    rstf = 1'b1;
    pend_m = '0;
    err_m  = 1'b0;
    tick();
    t_valid = 1'b0;
    checks++; if (act_iv !== 1'b1) begin errors++; $display("FAIL arst_release_issue: got %0b expected 1", act_iv); end
  endtask

  task automatic test_random();
    logic [6:0] ops [11];
    int q[$];
    ops = '{B_LUI, B_AUIPC, B_JAL, B_JALR, B_BRANCH, B_LOAD, B_STORE,
            B_ALU_IMM, B_ALU, B_MISC_MEM, B_SYS};
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      if (n % 1000 == 999) do_reset();
      t_valid = ($urandom_range(3) != 0);
      i_ready = ($urandom_range(3) != 0);
      if (!(exp_iv == 1'b0 && t_valid && $urandom_range(2) != 0))
        t_instr = enc(ops[$urandom_range(10)], $urandom_range(7), $urandom_range(7),
                      $urandom_range(7), $urandom_range(7));
      q.delete();
      for (int r = 0; r < 32; r++) if (pend_m[r]) q.push_back(r);
      wb_valid = ($urandom_range(2) == 0);
      if (q.size() > 0 && $urandom_range(15) != 0) wb_rd = 5'(q[$urandom_range(q.size() - 1)]);
      else wb_rd = 5'($urandom_range(31));
      flush = ($urandom_range(59) == 0);
      tick();
      checks++; if (act_iv !== exp_iv) begin errors++; $display("FAIL rnd_i_valid n=%0d: got %0b expected %0b", n, act_iv, exp_iv); end
      checks++; if (act_tr !== exp_tr) begin errors++; $display("FAIL rnd_t_ready n=%0d: got %0b expected %0b", n, act_tr, exp_tr); end
      checks++; if (busy_mask !== pend_m) begin errors++; $display("FAIL rnd_busy n=%0d: got %h expected %h", n, busy_mask, pend_m); end
      checks++; if (int'(inflight) != $countones(pend_m)) begin errors++; $display("FAIL rnd_inflight n=%0d: got %0d expected %0d", n, inflight, $countones(pend_m)); end
      checks++; if (sb_err !== err_m) begin errors++; $display("FAIL rnd_sb_err n=%0d: got %0b expected %0b", n, sb_err, err_m); end
    end
    t_valid = 1'b0; wb_valid = 1'b0; flush = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_raw();
    test_capacity();
    test_waw();
    test_bad_wb();
    test_flush();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
